// File: rtl/booth_mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
package booth_mult_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter width: must hold WIDTH+1
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic right shift.
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] acc_nx,
  output logic [WIDTH:0]   q_nx,
  output logic             q_m1_nx
);

  logic [WIDTH+1:0] sum;

  // Booth recoding of {Q[0], q_m1} followed by the shift of {A, Q, q_m1}
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nx  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_nx    = {sum[0], q[WIDTH:1]};
    q_m1_nx = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, WIDTH+1 cycles per product.
module booth_mult_seq
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned QW = WIDTH + 1;
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_e          state, state_nx;
  logic [AW-1:0]   acc, m_reg, acc_step, m_ext;
  logic [QW-1:0]   q, q_step, q_ext;
  logic            q_m1, q_m1_step;
  logic [CW-1:0]   cnt;
  logic            load, iterate, finish;

  assign m_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign q_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .q       (q),
    .q_m1    (q_m1),
    .m       (m_reg),
    .acc_nx  (acc_step),
    .q_nx    (q_step),
    .q_m1_nx (q_m1_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath control; the cnt==1 iteration is the last one
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    iterate  = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        iterate = 1'b1;
        if (cnt == CW'(1)) begin
          finish   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture and per-cycle iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      m_reg <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      m_reg <= m_ext;
      q     <= q_ext;
      q_m1  <= 1'b0;
      cnt   <= CW'(WIDTH + 1);
    end else if (iterate) begin
      acc   <= acc_step;
      q     <= q_step;
      q_m1  <= q_m1_step;
      cnt   <= cnt - CW'(1);
    end
  end

  // Registered status and product; product taken from the final iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      p    <= '0;
    end else begin
      busy <= (state_nx == ST_RUN);
      done <= finish;
      if (finish) p <= PW'({acc_step, q_step});
    end
  end

endmodule
